// File: rtl/operand_b_stage.sv
// ALU B-operand stage: selects a source word, applies the immediate transform
// and holds the result in a valid/ready output register backed by a one-entry skid.
module operand_b_stage #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic                     sel_err,
  output logic [1:0]               dbg_state
);

  // Handshake: a beat moves on an edge where valid && ready; the producer holds
  // data steady while valid && !ready, and ready never depends on the peer's valid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_sel_err;

  logic             w_skid_valid;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_hit;
  logic [WIDTH-1:0] w_sel_word;
  logic [WIDTH-1:0] w_ext_s;
  logic [WIDTH-1:0] w_ext_z;
  logic [WIDTH-1:0] w_xform;

  // An out-of-range select matches no source and yields a zero beat.
  always_comb begin
    w_hit      = 1'b0;
    w_sel_word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        w_hit      = 1'b1;
        w_sel_word = src_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ext_s = {{(WIDTH-16){w_sel_word[15]}}, w_sel_word[15:0]};
  assign w_ext_z = {{(WIDTH-16){1'b0}}, w_sel_word[15:0]};

  always_comb begin
    w_xform = '0;
    if (w_hit) begin
      case (mode)
        2'b00:   w_xform = w_sel_word;
        2'b01:   w_xform = w_ext_s;
        2'b10:   w_xform = w_ext_z;
        default: w_xform = {w_ext_s[WIDTH-3:0], 2'b00};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
      ST_ONE: begin
        if (w_drain && !w_accept)      w_next_state = ST_EMPTY;
        else if (!w_drain && w_accept) w_next_state = ST_FULL;
      end
      ST_FULL:  if (w_drain) w_next_state = ST_ONE;
      default:  w_next_state = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid    = (r_state == ST_ONE) || (r_state == ST_FULL);
    w_skid_valid = (r_state == ST_FULL);
    in_ready     = !w_skid_valid;
    out_data     = r_out_data;
    sel_err      = r_sel_err;
    dbg_state    = r_state;
  end

  assign w_accept    = in_valid && in_ready;
  assign w_drain     = out_valid && out_ready;
  assign w_load_out  = ((r_state == ST_EMPTY) && w_accept) ||
                       ((r_state == ST_ONE) && w_drain && w_accept) ||
                       ((r_state == ST_FULL) && w_drain);
  assign w_load_skid = (r_state == ST_ONE) && w_accept && !w_drain;

  // Beats are transformed once on entry; the skid word moves over unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
      r_sel_err   <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_out_data <= (r_state == ST_FULL) ? r_skid_data : w_xform;
      end
      if (w_load_skid) begin
        r_skid_data <= w_xform;
      end
      if (w_accept && !w_hit) begin
        r_sel_err <= 1'b1;
      end else if (err_clr) begin
        r_sel_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_b_stage.sv
// Bench for operand_b_stage (WIDTH=32, NUM_SRC=3) against a two-deep queue model.
module tb_operand_b_stage;
  localparam int W  = 32;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  src [NS];
  logic [NS*W-1:0] src_bus;
  logic [1:0]    sel;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          err_clr;
  logic          sel_err;
  logic [1:0]    dbg_state;

  int            n_asserts = 0;
  int            n_fail    = 0;
  logic [W-1:0]  exp_q[$];
  logic          m_err;

  always #5 clk = ~clk;

  assign src_bus = {src[2], src[1], src[0]};

  operand_b_stage #(.WIDTH(W), .NUM_SRC(NS)) dut (
    .clk(clk), .reset_n(reset_n), .src_bus(src_bus), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_clr(err_clr),
    .sel_err(sel_err), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xf(input logic [31:0] w, input logic [1:0] m, input logic bad);
    int unsigned lo;
    int unsigned se;
    if (bad) return 32'd0;
    lo = w % 65536;
    se = (lo >= 32768) ? lo + 32'hFFFF_0000 : lo;
    case (m)
      2'b00:   return w;
      2'b01:   return se;
      2'b10:   return lo;
      default: return se * 4;
    endcase
  endfunction

  task automatic check_model();
    chk("out_valid", {31'b0, out_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
    chk("in_ready", {31'b0, in_ready}, (exp_q.size() < 2) ? 32'd1 : 32'd0);
    chk("sel_err", {31'b0, sel_err}, {31'b0, m_err});
    if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
  endtask

  // One clock: predict from pre-edge inputs, advance the model, then compare.
  task automatic cycle();
    logic         acc, drn, bad, stall;
    logic [31:0]  word, held;
    bad   = (sel >= 2'd3);
    word  = 32'd0;
    if (!bad) word = src[sel];
    acc   = in_valid && (exp_q.size() < 2);
    drn   = out_ready && (exp_q.size() > 0);
    stall = (exp_q.size() > 0) && !out_ready;
    held  = stall ? exp_q[0] : 32'd0;
    @(posedge clk);
    if (drn) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(xf(word, mode, bad));
    if (acc && bad) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    #1;
    check_model();
    if (stall) chk("stable", out_data, held);
  endtask

  initial begin
    reset_n = 1'b0; sel = 2'd0; mode = 2'd0; in_valid = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0; m_err = 1'b0;
    src[0] = 32'd0; src[1] = 32'd0; src[2] = 32'd0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_sel_err", {31'b0, sel_err}, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_ignores_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Pass-through and back-to-back throughput
    src[1] = 32'h1234_5678; sel = 2'd1; mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("pass", out_data, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      src[1] = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    cycle();

    // Immediate transforms
    src[2] = 32'h0000_8004; sel = 2'd2; in_valid = 1'b1;
    mode = 2'b01; cycle(); chk("sext", out_data, 32'hFFFF_8004);
    mode = 2'b10; cycle(); chk("zext", out_data, 32'h0000_8004);
    mode = 2'b11; cycle(); chk("sext_sh2", out_data, 32'hFFFE_0010);
    in_valid = 1'b0; cycle();

    // Stall and skid ordering
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; mode = 2'b00;
    src[0] = 32'hAAAA_0001; cycle();
    chk("stall_a", out_data, 32'hAAAA_0001);
    chk("stall_a_rdy", {31'b0, in_ready}, 32'd1);
    src[0] = 32'hBBBB_0002; cycle();
    chk("stall_b_rdy", {31'b0, in_ready}, 32'd0);
    src[0] = 32'hCCCC_0003; cycle();
    chk("stall_c_held", out_data, 32'hAAAA_0001);
    out_ready = 1'b1; cycle();
    chk("drain_b", out_data, 32'hBBBB_0002);
    cycle();
    chk("drain_c", out_data, 32'hCCCC_0003);
    in_valid = 1'b0; cycle();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Bad select and sticky error
    sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1; src[0] = 32'hDEAD_BEEF;
    cycle();
    chk("bad_data", out_data, 32'd0);
    chk("bad_err", {31'b0, sel_err}, 32'd1);
    err_clr = 1'b1; cycle();
    chk("err_set_wins", {31'b0, sel_err}, 32'd1);
    in_valid = 1'b0; cycle();
    chk("err_cleared", {31'b0, sel_err}, 32'd0);
    err_clr = 1'b0;

    // Asynchronous reset from FULL
    sel = 2'd3; in_valid = 1'b1; out_ready = 1'b0; cycle();
    sel = 2'd1; src[1] = 32'h5555_AAAA; cycle();
    chk("full_before_rst", {31'b0, in_ready}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_sel_err", {31'b0, sel_err}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    exp_q.delete(); m_err = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_model();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 2'($urandom_range(0, 3));
      mode      = 2'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 7) == 0);
      src[0] = $urandom; src[1] = $urandom; src[2] = $urandom;
      if ($urandom_range(0, 3) == 0) src[sel % 2'd3] = {16'h0, 1'b1, 15'($urandom)};
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_b_stage.md
# operand_b_stage

Registered, parametrised successor to the ALU B-operand selector in the multicycle datapath. Picks one of `NUM_SRC` packed source words, applies an immediate transform (pass, sign-extend, zero-extend, sign-extend then shift-left-2), and presents the result through a valid/ready output register backed by a one-entry skid buffer. It sits between the register-file/immediate sources and the ALU B port. This decouples control-unit stalls from operand generation without losing a beat.

## Interface
- `WIDTH`, 32: datapath width in bits; must be >= 18.
- `NUM_SRC`, 4: number of selectable sources; >= 2.
- `SEL_W`, `$clog2(NUM_SRC)`: select width; derived, not overridden.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `src_bus`  in  NUM_SRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- `sel`  in  SEL_W  source index for the current beat.
- `mode`  in  2  transform: 00 pass, 01 sign-ext low 16, 10 zero-ext low 16, 11 sign-ext low 16 then <<2.
- `in_valid`  in  1  input beat offered.
- `in_ready`  out  1  stage can accept a beat.
- `out_data`  out  WIDTH  transformed operand.
- `out_valid`  out  1  `out_data` holds a valid beat.
- `out_ready`  in  1  consumer accepts `out_data`.
- `err_clr`  in  1  clears `sel_err`.
- `sel_err`  out  1  sticky: an accepted beat had `sel >= NUM_SRC`.

## Operation
- Accept = `in_valid && in_ready`; drain = `out_valid && out_ready`.
- The transform is combinational on the accepted beat and is applied before storage. Stored beats are never re-transformed.
- Sign-extend replicates bit 15 into bits [WIDTH-1:16]. Zero-extend fills those bits with 0.
- Mode 11 sign-extends first, then shifts left 2: the low 2 bits are 0 and the top 2 bits of the extended word are discarded.
- `sel >= NUM_SRC`: the beat is accepted with data 0 and `sel_err` is set.
- State: output register (`out_valid`, `out_data`) and skid register (`skid_valid`, `skid_data`).
- States: EMPTY (neither valid), ONE (output valid, skid empty), FULL (both valid).
- EMPTY: accept loads the output register, moving to ONE.
- ONE, drain with no accept: move to EMPTY.
- ONE, drain with accept: the output register reloads from input and the state stays ONE.
- ONE, accept without drain: the beat goes to the skid register, moving to FULL.
- ONE, neither accept nor drain: hold.
- FULL: no accept is possible. On drain, the skid beat moves to the output register, moving to ONE. Without drain, hold.
- `in_ready = !skid_valid`. It is a registered-state function, with no combinational path from `out_ready`.
- Ordering is strict FIFO; beats are never dropped or duplicated.
- `out_data` stays stable while `out_valid && !out_ready`.
- `sel_err`: set on an accepted bad-select beat and cleared by `err_clr`. If both occur in the same cycle, set wins.

## Timing
- Reset (asynchronous, immediate on `reset_n` low): `out_valid`=0, `out_data`=0, `skid_valid`=0, `skid_data`=0, `sel_err`=0.
- `in_ready` is 1 while in reset, but `in_valid` is ignored until the first edge after `reset_n` rises.
- Latency: a beat accepted at edge N is visible on `out_data`/`out_valid` after edge N; the consumer can take it at edge N+1.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` falls the cycle after a beat enters the skid register. It rises the cycle after the skid register drains.
- Reset mid-transfer discards both registered beats; there is no partial output.
- `sel_err` updates at the edge of acceptance and is visible the next cycle.

## Test plan
- Pass-through: WIDTH=32, src1=0x1234_5678, sel=1, mode=00, `out_ready`=1. Expect `out_data`=0x1234_5678 one cycle after accept; back-to-back beats give 1 beat/cycle.
- Transforms: src2=0x0000_8004. Mode 01 -> 0xFFFF_8004; mode 10 -> 0x0000_8004; mode 11 -> 0xFFFE_0010.
- Stall/skid: hold `out_ready`=0 and offer beats A, B, C.
  - A goes to the output register and B to the skid register.
  - `in_ready`=0 the cycle after B, so C is held.
  - Release `out_ready`: drain order is A, B, C, with no loss.
- Bad select: NUM_SRC=3, sel=3, accept. Expect `out_data`=0 and `sel_err`=1 thereafter. Pulse `err_clr` together with another bad beat: `sel_err` stays 1. A lone `err_clr` clears it.
- Reset mid-operation: FULL state, drop `reset_n`. Expect `out_valid`=0, `out_data`=0, `sel_err`=0 immediately, with no clock edge needed; `in_ready`=1.
- Random: random valid/ready/sel/mode against a scoreboard model. Check ordering, stability under stall, and `in_ready == !skid_valid`.
